shr_chain_prog: RTL and testbench

Parametrised serial shift-register programmer for the board's external shift-register chains. It replaces the single-chain, fixed-length trigger/dump programmer. It drives N_CH independent DIN lines from one shared SCLK and SYNC, with a programmable SCLK divider and per-channel enable. It also captures each chain's DOUT into a readback register. It sits between the vJTAG buffer (parallel image source) and the GPIO header pins.

---
 rtl/shr_chain_prog.sv | 244 ++++++++++++++++++++++++
 tb/tb_shr_chain_prog.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shr_chain_prog.sv
// Serial shift-register chain programmer.
// Drives N_CH parallel DIN lines from one shared SCLK/SYNC pair. Each
// transaction shifts a DATA_W-bit image per chain MSB first, then issues a
// SYNC strobe. The DOUT of each chain can optionally be captured into a
// readback register.
module shr_chain_prog #(
  parameter int DATA_W  = 491,
  parameter int N_CH    = 2,
  parameter int DIV_W   = 8,
  parameter int SYN_LEN = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   trig,
  input  logic                   dump,
  input  logic [1:0]             clr_mode,
  input  logic [DIV_W-1:0]       div,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [N_CH*DATA_W-1:0] data_reg,
  input  logic [N_CH-1:0]        dout,
  output logic                   sclk,
  output logic [N_CH-1:0]        din,
  output logic                   syn,
  output logic [N_CH*DATA_W-1:0] rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   out_en,
  output logic                   clk_out_en
);

  // The bit counter is shared between SHIFT (data bits) and SYNC (half-periods).
  localparam int CNT_SPAN = (DATA_W > 2 * SYN_LEN) ? DATA_W : 2 * SYN_LEN;
  localparam int CNT_W    = (CNT_SPAN > 2) ? $clog2(CNT_SPAN) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SYNC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Trigger synchroniser and edge-detect history
  logic trig_s1_q, trig_s2_q, trig_s3_q;
  logic trig_rise;

  // Timing counters and shift clock
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             sclk_q, sclk_d;

  // Per-transaction configuration
  logic [DIV_W-1:0] div_q, div_d;
  logic [N_CH-1:0]  en_q, en_d;
  logic             dump_q, dump_d;
  logic [1:0]       mode_q, mode_d;

  // Shift, capture and readback storage
  logic [N_CH-1:0][DATA_W-1:0] sh_q, sh_d;
  logic [N_CH-1:0][DATA_W-1:0] cap_q, cap_d;
  logic [N_CH*DATA_W-1:0]      rd_q, rd_d;

  logic tick;
  logic sclk_fall;

  // Image selection for one channel according to the clear mode.
  function automatic logic [DATA_W-1:0] src_word(input logic [1:0] mode,
                                                 input logic [DATA_W-1:0] img);
    logic [DATA_W-1:0] w;
    case (mode)
      2'b00:   w = img;
      2'b10:   w = '1;
      default: w = '0;
    endcase
    return w;
  endfunction

  assign trig_rise = trig_s2_q & ~trig_s3_q;
  // One divider period has elapsed when the counter reaches the latched div.
  assign tick      = (cnt_q == div_q);
  assign sclk_fall = tick & sclk_q;
  assign rd_data   = rd_q;

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; trigger edges outside IDLE are simply dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trig_rise) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (sclk_fall && (bcnt_q == '0)) state_d = S_SYNC;
      S_SYNC:  if (tick && (bcnt_q == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; din is gated so idle/sync/disabled lines sit at 0
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    out_en     = (state_q == S_SHIFT);
    clk_out_en = (state_q == S_SHIFT);
    syn        = (state_q == S_SYNC);
    sclk       = sclk_q;
    din        = '0;
    if (state_q == S_SHIFT) begin
      for (int c = 0; c < N_CH; c++) begin
        din[c] = en_q[c] & sh_q[c][DATA_W-1];
      end
    end
  end

  // Datapath next-state: divider, bit counter, shifting, capture and readback
  always_comb begin
    cnt_d  = cnt_q;
    bcnt_d = bcnt_q;
    sclk_d = sclk_q;
    div_d  = div_q;
    en_d   = en_q;
    dump_d = dump_q;
    mode_d = mode_q;
    sh_d   = sh_q;
    cap_d  = cap_q;
    rd_d   = rd_q;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bcnt_d = '0;
        sclk_d = 1'b0;
        if (trig_rise) begin
          div_d  = div;
          en_d   = ch_en;
          dump_d = dump;
          mode_d = clr_mode;
        end
      end
      S_LOAD: begin
        cnt_d  = '0;
        bcnt_d = CNT_W'(DATA_W - 1);
        sclk_d = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
          sh_d[c] = src_word(mode_q, data_reg[c*DATA_W +: DATA_W]);
        end
      end
      S_SHIFT: begin
        if (tick) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising sclk: sample the returned bit, first bit ends up at MSB
            for (int c = 0; c < N_CH; c++) begin
              cap_d[c] = {cap_q[c][DATA_W-2:0], dout[c]};
            end
          end else begin
            // Falling sclk: present the next bit
            for (int c = 0; c < N_CH; c++) begin
              sh_d[c] = {sh_q[c][DATA_W-2:0], 1'b0};
            end
            if (bcnt_q == '0) begin
              bcnt_d = CNT_W'(2 * SYN_LEN - 1);
            end else begin
              bcnt_d = bcnt_q - CNT_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_SYNC: begin
        sclk_d = 1'b0;
        if (tick) begin
          cnt_d = '0;
          if (bcnt_q != '0) begin
            bcnt_d = bcnt_q - CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        cnt_d  = '0;
        bcnt_d = '0;
        sclk_d = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
          if (dump_q && en_q[c]) begin
            rd_d[c*DATA_W +: DATA_W] = cap_q[c];
          end
        end
      end
      default: begin
        cnt_d  = '0;
        bcnt_d = '0;
        sclk_d = 1'b0;
      end
    endcase
  end

  // Control registers, synchroniser and readback, cleared by reset
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_s3_q <= 1'b0;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      sclk_q    <= 1'b0;
      div_q     <= '0;
      en_q      <= '0;
      dump_q    <= 1'b0;
      mode_q    <= 2'b00;
      rd_q      <= '0;
    end else begin
      trig_s1_q <= trig;
      trig_s2_q <= trig_s1_q;
      trig_s3_q <= trig_s2_q;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      sclk_q    <= sclk_d;
      div_q     <= div_d;
      en_q      <= en_d;
      dump_q    <= dump_d;
      mode_q    <= mode_d;
      rd_q      <= rd_d;
    end
  end

  // Shift and capture storage; always reloaded before use, so no reset
  always_ff @(posedge clk_in) begin
    sh_q  <= sh_d;
    cap_q <= cap_d;
  end

endmodule

// File: tb/tb_shr_chain_prog.sv
// Bench for shr_chain_prog: directed and random transactions, with a
// scoreboard of per-transaction expectations checked by a monitor.
module tb_shr_chain_prog;

  localparam int DW  = 8;
  localparam int NC  = 2;
  localparam int DVW = 8;
  localparam int SL  = 2;

  logic              clk_in   = 1'b0;
  logic              rst_n    = 1'b0;
  logic              trig     = 1'b0;
  logic              dump     = 1'b0;
  logic [1:0]        clr_mode = 2'b00;
  logic [DVW-1:0]    div      = '0;
  logic [NC-1:0]     ch_en    = '0;
  logic [NC*DW-1:0]  data_reg = '0;
  logic [NC-1:0]     xr       = '0;
  logic [NC-1:0]     dout;
  logic              sclk;
  logic [NC-1:0]     din;
  logic              syn;
  logic [NC*DW-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic              out_en;
  logic              clk_out_en;

  // Chain model: returned data is the sent data, optionally inverted per channel
  assign dout = din ^ xr;

  shr_chain_prog #(.DATA_W(DW), .N_CH(NC), .DIV_W(DVW), .SYN_LEN(SL)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .trig(trig), .dump(dump),
    .clr_mode(clr_mode), .div(div), .ch_en(ch_en), .data_reg(data_reg),
    .dout(dout), .sclk(sclk), .din(din), .syn(syn), .rd_data(rd_data),
    .busy(busy), .done(done), .out_en(out_en), .clk_out_en(clk_out_en)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_exp = 0;

  typedef struct packed {
    logic [31:0]      len;
    logic [31:0]      oe;
    logic [31:0]      sy;
    logic [31:0]      half;
    logic [NC*DW-1:0] seq;
    logic [NC*DW-1:0] rd;
  } exp_t;

  exp_t             sb_q[$];
  logic [NC*DW-1:0] rd_model = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: what the chains should see and what readback should hold
  task automatic push_exp(input logic [NC*DW-1:0] dr, input logic [1:0] mode,
                          input logic [DVW-1:0] dv, input logic [NC-1:0] en,
                          input logic dmp, input logic [NC-1:0] x);
    exp_t          e;
    logic [DW-1:0] src;
    int            h;
    h = int'(dv) + 1;
    e = '0;
    for (int c = 0; c < NC; c++) begin
      if (mode == 2'b00)      src = dr[c*DW +: DW];
      else if (mode == 2'b10) src = '1;
      else                    src = '0;
      e.seq[c*DW +: DW] = en[c] ? src : '0;
      if (dmp && en[c]) rd_model[c*DW +: DW] = src ^ {DW{x[c]}};
    end
    e.len  = 32'(2 + 2 * h * DW + 2 * h * SL);
    e.oe   = 32'(2 * h * DW);
    e.sy   = 32'(2 * h * SL);
    e.half = 32'(h * DW);
    e.rd   = rd_model;
    sb_q.push_back(e);
    done_exp++;
  endtask

  // Monitor: observes each transaction and checks it against the scoreboard
  int                    m_len, m_oe, m_sy, m_hi, m_lo, m_rise, m_coe, m_dinbad, m_sclkbad;
  logic [NC-1:0][DW-1:0] m_seq;
  logic                  m_active = 1'b0;
  logic                  m_prev_sclk = 1'b0;
  logic                  m_pend = 1'b0;
  exp_t                  m_exp;

  always @(negedge clk_in) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_pend = 1'b0;
      m_prev_sclk = 1'b0;
    end else begin
      if (m_pend) begin
        chk("rd_data", rd_data, m_exp.rd);
        m_pend = 1'b0;
      end
      if (busy && !m_active) begin
        m_active = 1'b1;
        m_len = 0; m_oe = 0; m_sy = 0; m_hi = 0; m_lo = 0; m_rise = 0;
        m_coe = 0; m_dinbad = 0; m_sclkbad = 0;
        m_seq = '0;
        m_prev_sclk = 1'b0;
      end
      if (m_active) begin
        m_len++;
        if (out_en) m_oe++;
        if (syn) m_sy++;
        if (clk_out_en !== out_en) m_coe++;
        if (out_en && sclk) m_hi++;
        if (out_en && !sclk) m_lo++;
        if (!out_en && (din != '0)) m_dinbad++;
        if (!out_en && sclk) m_sclkbad++;
        if (sclk && !m_prev_sclk) begin
          m_rise++;
          for (int c = 0; c < NC; c++) m_seq[c] = {m_seq[c][DW-2:0], din[c]};
        end
        m_prev_sclk = sclk;
        if (done) begin
          done_seen++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got a transaction, expected none queued");
          end else begin
            m_exp = sb_q.pop_front();
            chk("txn_length", 64'(m_len), 64'(m_exp.len));
            chk("out_en_cycles", 64'(m_oe), 64'(m_exp.oe));
            chk("syn_cycles", 64'(m_sy), 64'(m_exp.sy));
            chk("sclk_high_cycles", 64'(m_hi), 64'(m_exp.half));
            chk("sclk_low_cycles", 64'(m_lo), 64'(m_exp.half));
            chk("sclk_rises", 64'(m_rise), 64'(DW));
            chk("din_sequence", 64'(m_seq), 64'(m_exp.seq));
            chk("clk_out_en_match", 64'(m_coe), 64'd0);
            chk("din_idle_zero", 64'(m_dinbad), 64'd0);
            chk("sclk_idle_zero", 64'(m_sclkbad), 64'd0);
            m_pend = 1'b1;
          end
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic run_txn(input logic [NC*DW-1:0] dr, input logic [1:0] mode,
                         input logic [DVW-1:0] dv, input logic [NC-1:0] en,
                         input logic dmp, input logic [NC-1:0] x,
                         input int disturb, input int hold);
    int k;
    int lim;
    @(posedge clk_in); #1;
    data_reg = dr; clr_mode = mode; div = dv; ch_en = en; dump = dmp; xr = x;
    push_exp(dr, mode, dv, en, dmp, x);
    trig = 1'b1;
    k = 0;
    do begin
      @(posedge clk_in); #1;
      k++;
    end while (!busy && k < 20);
    chk("trig_to_busy", 64'(k), 64'd3);
    if (disturb != 0) begin
      k = 0;
      while (!out_en && k < 20) begin
        @(posedge clk_in); #1;
        k++;
      end
      repeat (5) @(posedge clk_in);
      #1;
      trig = 1'b0; data_reg = ~dr; ch_en = ~en; div = dv + 1'b1; clr_mode = ~mode; dump = ~dmp;
      repeat (3) @(posedge clk_in);
      #1;
      trig = 1'b1;
    end
    lim = 2 * (int'(dv) + 1) * (DW + SL) + 40;
    k = 0;
    while (busy && k < lim) begin
      @(posedge clk_in); #1;
      k++;
    end
    chk("busy_released", 64'(busy), 64'd0);
    repeat (hold) @(posedge clk_in);
    #1;
    trig = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    chk("idle_after_txn", 64'(busy), 64'd0);
  endtask

  task automatic reset_mid();
    int k;
    int d0;
    @(posedge clk_in); #1;
    data_reg = 16'hF00F; clr_mode = 2'b00; div = 8'd1; ch_en = 2'b11; dump = 1'b1; xr = 2'b00;
    trig = 1'b1;
    k = 0;
    while (!out_en && k < 20) begin
      @(posedge clk_in); #1;
      k++;
    end
    repeat (6) @(posedge clk_in);
    #3;
    chk("pre_reset_out_en", 64'(out_en), 64'd1);
    chk("pre_reset_rd", 64'(rd_data), 64'(rd_model));
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_din", 64'(din), 64'd0);
    chk("rst_syn", 64'(syn), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_en", 64'(out_en), 64'd0);
    chk("rst_clk_out_en", 64'(clk_out_en), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    rd_model = '0;
    trig = 1'b0;
    repeat (3) @(posedge clk_in);
    #3;
    rst_n = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    chk("no_done_after_abort", 64'(done_seen), 64'(d0));
    chk("idle_after_reset", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [NC*DW-1:0] r_dr;
    logic [1:0]       r_mode;
    logic [DVW-1:0]   r_dv;
    logic [NC-1:0]    r_en;
    logic             r_dmp;
    logic [NC-1:0]    r_x;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_sclk", 64'(sclk), 64'd0);
    chk("reset_din", 64'(din), 64'd0);
    chk("reset_syn", 64'(syn), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_out_en", 64'(out_en), 64'd0);
    chk("reset_clk_out_en", 64'(clk_out_en), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_in);

    run_txn(16'hA53C, 2'b00, 8'd0, 2'b11, 1'b1, 2'b00, 0, 0);
    run_txn(16'h1234, 2'b00, 8'd0, 2'b11, 1'b0, 2'b00, 0, 0);
    run_txn(16'h0000, 2'b10, 8'd3, 2'b11, 1'b1, 2'b00, 0, 0);
    run_txn(16'h5A96, 2'b00, 8'd2, 2'b01, 1'b1, 2'b11, 0, 0);
    run_txn(16'hA53C, 2'b00, 8'd0, 2'b11, 1'b1, 2'b00, 1, 0);
    run_txn(16'hC3E1, 2'b00, 8'd0, 2'b11, 1'b1, 2'b01, 0, 200);
    reset_mid();
    run_txn(16'h7E81, 2'b00, 8'd1, 2'b11, 1'b1, 2'b00, 0, 0);
    for (int i = 0; i < 8; i++) begin
      r_dr   = 16'($urandom);
      r_mode = 2'($urandom_range(0, 3));
      r_dv   = 8'($urandom_range(0, 4));
      r_en   = 2'($urandom_range(0, 3));
      r_dmp  = 1'($urandom_range(0, 1));
      r_x    = 2'($urandom_range(0, 3));
      run_txn(r_dr, r_mode, r_dv, r_en, r_dmp, r_x, 0, 0);
    end
    r_dr = 16'($urandom);
    run_txn(r_dr, 2'b01, 8'hFF, 2'b11, 1'b1, 2'b10, 0, 0);

    repeat (10) @(posedge clk_in);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    chk("done_count", 64'(done_seen), 64'(done_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
